// File: rtl/i2c_xlate_arbiter_if.sv
// Bus bundle for i2c_xlate_arbiter. The slave modport is the arbiter's view;
// master is the host/requester/i2c_master environment driving it.
interface i2c_xlate_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int XLATE_ENTRIES = 8
);
    localparam int IDX_W = $clog2(XLATE_ENTRIES);

    logic [NUM_REQ-1:0]   req;
    logic [7*NUM_REQ-1:0] req_vaddr;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [1:0]           rsp_status;

    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_idx;
    logic [6:0]           cfg_vaddr;
    logic [6:0]           cfg_paddr;
    logic                 cfg_valid;

    logic                 m_start_req;
    logic [6:0]           m_slave_addr;
    logic                 m_rw_bit;
    logic [7:0]           m_data_in;
    logic                 m_busy;
    logic                 m_ack_error;
    logic                 m_done;
    logic                 arb_busy;

    modport slave (
        input  req, req_vaddr, req_data, cfg_we, cfg_idx, cfg_vaddr, cfg_paddr, cfg_valid,
               m_busy, m_ack_error, m_done,
        output gnt, rsp_valid, rsp_status, m_start_req, m_slave_addr, m_rw_bit, m_data_in,
               arb_busy
    );

    modport master (
        output req, req_vaddr, req_data, cfg_we, cfg_idx, cfg_vaddr, cfg_paddr, cfg_valid,
               m_busy, m_ack_error, m_done,
        input  gnt, rsp_valid, rsp_status, m_start_req, m_slave_addr, m_rw_bit, m_data_in,
               arb_busy
    );
endinterface

// File: rtl/i2c_xlate_arbiter.sv
// Round-robin arbiter sharing one i2c_master write engine, with a programmable
// virtual->physical address CAM and start/busy/done sequencing.
module i2c_xlate_entry #(
    parameter int IDX_W = 3,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [6:0]       vaddr_i,
    input  logic [6:0]       paddr_i,
    input  logic             valid_i,
    input  logic [6:0]       lookup_i,
    output logic             hit_o,
    output logic [6:0]       paddr_o
);
    logic       vld_q;
    logic [6:0] va_q;
    logic [6:0] pa_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            va_q  <= '0;
            pa_q  <= '0;
        end else if (we_i && idx_i == IDX_W'(IDX)) begin
            vld_q <= valid_i;
            va_q  <= vaddr_i;
            pa_q  <= paddr_i;
        end
    end

    assign hit_o   = vld_q && (va_q == lookup_i);
    assign paddr_o = pa_q;
endmodule

module i2c_xlate_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int XLATE_ENTRIES  = 8,
    parameter int ACCEPT_TIMEOUT = 16,
    parameter int DONE_TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i2c_xlate_arbiter_if.slave   bus
);
    localparam int RW    = $clog2(NUM_REQ);
    localparam int IDX_W = $clog2(XLATE_ENTRIES);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e             state_q;
    logic [RW-1:0]      ptr_q, sel_q;
    logic [6:0]         vaddr_q;
    logic [7:0]         data_q;
    logic [NUM_REQ-1:0] gnt_q, rsp_valid_q;
    logic [1:0]         rsp_status_q, status_q;
    logic               start_q;
    logic [6:0]         slave_addr_q;
    logic [7:0]         data_in_q;
    logic [15:0]        cnt_q;
    logic [15:0]        cnt_d;

    logic [RW-1:0]      pick_d, ptr_d;
    logic               any_req_d;

    logic [XLATE_ENTRIES-1:0] ent_hit;
    logic [6:0]               ent_pa [XLATE_ENTRIES];
    logic                     lk_hit_d;
    logic [6:0]               lk_pa_d;

    for (genvar e = 0; e < XLATE_ENTRIES; e++) begin : g_ent
        i2c_xlate_entry #(.IDX_W(IDX_W), .IDX(e)) u_ent (
            .clk      (clk),
            .rst_n    (rst_n),
            .we_i     (bus.cfg_we),
            .idx_i    (bus.cfg_idx),
            .vaddr_i  (bus.cfg_vaddr),
            .paddr_i  (bus.cfg_paddr),
            .valid_i  (bus.cfg_valid),
            .lookup_i (vaddr_q),
            .hit_o    (ent_hit[e]),
            .paddr_o  (ent_pa[e])
        );
    end

    // Scan from ptr upward with wrap; descending loop lets the nearest requester win.
    always_comb begin
        int j;
        j         = 0;
        pick_d    = ptr_q;
        any_req_d = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr_q) + k) % NUM_REQ;
            if (bus.req[j]) begin
                pick_d    = RW'(j);
                any_req_d = 1'b1;
            end
        end
        ptr_d = (pick_d == RW'(NUM_REQ - 1)) ? '0 : pick_d + 1'b1;
    end

    // Lowest matching index wins.
    always_comb begin
        lk_hit_d = 1'b0;
        lk_pa_d  = '0;
        for (int e = XLATE_ENTRIES - 1; e >= 0; e--) begin
            if (ent_hit[e]) begin
                lk_hit_d = 1'b1;
                lk_pa_d  = ent_pa[e];
            end
        end
    end

    assign cnt_d = cnt_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            sel_q        <= '0;
            vaddr_q      <= '0;
            data_q       <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_status_q <= 2'b00;
            status_q     <= 2'b00;
            start_q      <= 1'b0;
            slave_addr_q <= '0;
            data_in_q    <= '0;
            cnt_q        <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        sel_q   <= pick_d;
                        ptr_q   <= ptr_d;
                        vaddr_q <= bus.req_vaddr[7*pick_d +: 7];
                        data_q  <= bus.req_data[8*pick_d +: 8];
                        gnt_q   <= NUM_REQ'(1) << pick_d;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lk_hit_d) begin
                        slave_addr_q <= lk_pa_d;
                        data_in_q    <= data_q;
                        cnt_q        <= '0;
                        state_q      <= S_ISSUE;
                    end else begin
                        status_q <= 2'b10;
                        state_q  <= S_RESP;
                    end
                end
                S_ISSUE: begin
                    // Accept counter only advances while start is presented.
                    if (!start_q) begin
                        if (!bus.m_busy) start_q <= 1'b1;
                    end else if (bus.m_busy) begin
                        start_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end else if (cnt_d == 16'(ACCEPT_TIMEOUT)) begin
                        start_q  <= 1'b0;
                        status_q <= 2'b11;
                        state_q  <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_WAIT: begin
                    if (bus.m_done) begin
                        status_q <= {1'b0, bus.m_ack_error};
                        state_q  <= S_RESP;
                    end else if (cnt_d == 16'(DONE_TIMEOUT)) begin
                        status_q <= 2'b11;
                        state_q  <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    rsp_valid_q  <= NUM_REQ'(1) << sel_q;
                    rsp_status_q <= status_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_status   = rsp_status_q;
    assign bus.m_start_req  = start_q;
    assign bus.m_slave_addr = slave_addr_q;
    assign bus.m_rw_bit     = 1'b0;
    assign bus.m_data_in    = data_in_q;
    assign bus.arb_busy     = (state_q != S_IDLE);
endmodule
